mst_wr_arbiter: RTL and testbench
=================================

# mst_wr_arbiter

Packet-granular arbiter sharing the PCIe master write FIFO (mst_din/mst_wr_en) between two packet sources: requester 0 (receiver DMA engine) and requester 1 (status/descriptor writeback engine). Grants whole master-write packets (command word, address words, payload) so commands from the two sources are never interleaved inside the FIFO. Sits between the requesters and the master FIFO write port, and reports framing errors and per-requester packet counts for the register block.

## Interface
- MAX_WORDS, 40, longest legal packet in 18-bit words, including the command word; counter width is 8 bits, legal range 2-255.
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst_n  in  1  synchronous, active-low reset.
- req0_din  in  18  requester 0 word; [17] = start of packet (command word), [16] = last word, [15:0] = data.
- req0_valid  in  1  requester 0 word valid.
- req0_ready  out  1  word accepted when req0_valid & req0_ready.
- req1_din / req1_valid / req1_ready  in/in/out  18/1/1  same as requester 0.
- mst_din  out  18  registered FIFO write data.
- mst_wr_en  out  1  registered FIFO write strobe.
- mst_afull  in  1  FIFO almost full; asserted with at least 2 entries free.
- err_clr  in  1  clears sticky error flags.
- grant  out  2  one-hot current owner; 2'b00 when idle.
- err_frm  out  1  sticky: a word without [17] was presented while idle.
- err_len  out  1  sticky: a packet reached MAX_WORDS without [16].
- pkt_cnt0, pkt_cnt1  out  8  completed packets per requester, wrapping.

## Operation
- States: IDLE, GNT0, GNT1.
- IDLE, selection:
  - A requester is a candidate when reqN_valid & reqN_din[17].
  - One candidate: move to its GNTn.
  - Both candidates: round-robin; pointer rr selects requester 0 when rr=0. rr takes the opposite index of the requester whose packet last completed.
- IDLE, stray words:
  - For reqN_valid & ~reqN_din[17], assert reqN_ready combinationally the same cycle and drop the word. No write; set err_frm.
  - A requester that is also a candidate is never dropped.
- GNTn:
  - reqN_ready = ~mst_afull.
  - Each accepted word is copied to mst_din with mst_wr_en=1 on the next cycle.
  - Word counter wcnt starts at 0 and increments per accepted word.
- GNTn, end of packet:
  - Accepted word with [16]=1: go to IDLE, increment pkt_cntN, set rr.
  - Accepted word with wcnt == MAX_WORDS-1 and [16]=0: write it with [16] forced to 1, set err_len, go to IDLE, increment pkt_cntN, set rr. Further words from that requester without [17] are then dropped as stray words in IDLE.
  - A word with [17]=1 arriving mid-packet is passed through unchanged. No error is flagged, since the requester owns its framing.
- The non-granted requester's ready is always 0.
- Error flags:
  - err_clr clears err_frm and err_len.
  - If a set condition and err_clr occur in the same cycle, set wins.
- Reset values:
  - State, wcnt, pkt counters, flags, rr, grant, mst_din and mst_wr_en all reset to 0.
  - Reset mid-packet abandons the partial packet with no terminating word; requesters share sys_rst_n and restart framing.

## Timing
- Arbitration latency:
  - Start word valid in IDLE at cycle n: grant at n+1, word accepted at n+1, mst_wr_en at n+2.
  - Ready is never asserted for a packet start in IDLE.
- Throughput:
  - One word per cycle while granted and ~mst_afull.
  - One idle bubble cycle between consecutive packets, from the same or a different requester.
- mst_afull is sampled in the same cycle as ready. It must assert early enough to absorb the one registered word in flight.
- mst_wr_en deasserts the cycle after the last accepted word, or on any cycle with no accept.

## Configuration
- ARB_FIXED_PRIO_EN defined:
  - Requester 0 always wins simultaneous candidates; rr is unused.
  - Requester 1 can starve while requester 0 streams back-to-back packets.
- Undefined (default): round-robin as described above.

## Test plan
- Single 35-word packet on req0 (start word 0x290FF, last word with [16]=1), mst_afull=0: 35 consecutive mst_wr_en pulses starting 2 cycles after valid, data identical, pkt_cnt0=1, grant returns to 0.
- Both requesters present start words at the same cycle, three packets each, default build: grant order 0,1,0,1,0,1 and pkt_cnt0=pkt_cnt1=3. With ARB_FIXED_PRIO_EN: order 0,0,0,1,1,1.
- mst_afull toggled every 3 cycles during a req1 packet: no write while afull is sampled high, no words lost or duplicated, word count unchanged.
- req1 presents 0x00005 without [17] while idle: word dropped, err_frm=1, no mst_wr_en. Then err_clr pulse: err_frm=0.
- req0 packet of 50 words with MAX_WORDS=40: 40 words written, 40th has [16]=1, err_len=1. The remaining 10 are dropped and err_frm=1.
- sys_rst_n low for 1 cycle at word 10 of a req0 packet: next cycle grant=0, mst_wr_en=0, counters=0. A fresh req1 packet is then granted normally.

Source files
------------

// File: rtl/mst_wr_arbiter.sv
// mst_wr_arbiter: packet-granular arbiter in front of the PCIe master write FIFO.
// Requester 0 (receiver DMA) and requester 1 (status/descriptor writeback) each
// own the FIFO for a whole packet (command word through last word), so their
// commands never interleave. Reports framing/length errors and packet counts.
//
// Optional build macro: ARB_FIXED_PRIO_EN
//   defined   -> requester 0 always wins simultaneous packet starts
//   undefined -> round-robin between simultaneous packet starts (default)
//
// Handshake (both requester ports): a word transfers on a rising sys_clk edge
// where reqN_valid and reqN_ready are both high. reqN_ready may depend
// combinationally on reqN_valid/reqN_din (stray words in IDLE) and on
// mst_afull (while granted); the requester must hold valid and din stable
// until the transfer happens.
module mst_wr_arbiter #(
  parameter int MAX_WORDS = 40
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [17:0] req0_din,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [17:0] req1_din,
  input  logic        req1_valid,
  output logic        req1_ready,
  output logic [17:0] mst_din,
  output logic        mst_wr_en,
  input  logic        mst_afull,
  input  logic        err_clr,
  output logic [1:0]  grant,
  output logic        err_frm,
  output logic        err_len,
  output logic [7:0]  pkt_cnt0,
  output logic [7:0]  pkt_cnt1,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  // Index of the last legal word of a packet (wcnt value of word MAX_WORDS).
  localparam logic [7:0] LAST_IDX = 8'(MAX_WORDS - 1);

  state_t      state;
  logic [7:0]  wcnt;

  logic        cand0, cand1;
  logic        stray0, stray1;
  logic        pick1;
  logic        acc;
  logic [17:0] acc_word;
  logic        at_limit;
  logic        trunc;
  logic        acc_end;

  assign fsm_state = state;

  // A start word makes a candidate; any other valid word seen in IDLE is stray.
  assign cand0  = req0_valid & req0_din[17];
  assign cand1  = req1_valid & req1_din[17];
  assign stray0 = req0_valid & ~req0_din[17];
  assign stray1 = req1_valid & ~req1_din[17];

`ifdef ARB_FIXED_PRIO_EN
  // Requester 0 wins every tie; requester 1 only wins when alone.
  assign pick1 = cand1 & ~cand0;
`else
  logic rr;

  // Round-robin pointer: points away from the requester that last finished.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      rr <= 1'b0;
    end else if (acc_end) begin
      rr <= (state == GNT0);
    end
  end

  assign pick1 = cand1 & (~cand0 | rr);
`endif

  // Ready generation: stray words are swallowed in IDLE, the owner is
  // throttled by afull, the other requester is always held off.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = stray0;
        req1_ready = stray1;
      end
      GNT0:    req0_ready = ~mst_afull;
      GNT1:    req1_ready = ~mst_afull;
      default: begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
      end
    endcase
  end

  // Word accepted from the current owner, and whether it closes the packet.
  always_comb begin
    acc      = 1'b0;
    acc_word = req0_din;
    case (state)
      GNT0: begin
        acc      = req0_valid & req0_ready;
        acc_word = req0_din;
      end
      GNT1: begin
        acc      = req1_valid & req1_ready;
        acc_word = req1_din;
      end
      default: begin
        acc      = 1'b0;
        acc_word = req0_din;
      end
    endcase
  end

  assign at_limit = (wcnt == LAST_IDX);
  assign trunc    = acc & at_limit & ~acc_word[16];
  assign acc_end  = acc & (acc_word[16] | at_limit);

  // Arbitration FSM with registered FIFO write port, counters and error flags.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      grant     <= 2'b00;
      wcnt      <= 8'd0;
      mst_din   <= 18'd0;
      mst_wr_en <= 1'b0;
      err_frm   <= 1'b0;
      err_len   <= 1'b0;
      pkt_cnt0  <= 8'd0;
      pkt_cnt1  <= 8'd0;
    end else begin
      mst_wr_en <= 1'b0;
      // Clear first so a same-cycle set below takes precedence.
      if (err_clr) begin
        err_frm <= 1'b0;
        err_len <= 1'b0;
      end
      case (state)
        IDLE: begin
          wcnt <= 8'd0;
          if (stray0 | stray1) begin
            err_frm <= 1'b1;
          end
          if (cand0 | cand1) begin
            if (pick1) begin
              state <= GNT1;
              grant <= 2'b10;
            end else begin
              state <= GNT0;
              grant <= 2'b01;
            end
          end
        end
        GNT0, GNT1: begin
          if (acc) begin
            mst_wr_en <= 1'b1;
            // An over-long packet is closed by forcing the last-word bit.
            mst_din   <= {acc_word[17], acc_word[16] | trunc, acc_word[15:0]};
            wcnt      <= wcnt + 8'd1;
            if (acc_end) begin
              state <= IDLE;
              grant <= 2'b00;
              if (state == GNT0) begin
                pkt_cnt0 <= pkt_cnt0 + 8'd1;
              end else begin
                pkt_cnt1 <= pkt_cnt1 + 8'd1;
              end
              if (trunc) begin
                err_len <= 1'b1;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mst_wr_arbiter.sv
// Directed testbench for mst_wr_arbiter: per-scenario tasks with inline checks.
module tb_mst_wr_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [17:0] req0_din = '0;
  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [17:0] req1_din = '0;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [17:0] mst_din;
  logic        mst_wr_en;
  logic        mst_afull = 1'b0;
  logic        err_clr = 1'b0;
  logic [1:0]  grant;
  logic        err_frm;
  logic        err_len;
  logic [7:0]  pkt_cnt0;
  logic [7:0]  pkt_cnt1;
  logic [1:0]  fsm_state;

  int n_vec = 0;
  int n_err = 0;

  mst_wr_arbiter #(.MAX_WORDS(40)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .req0_din   (req0_din),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req1_din   (req1_din),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .mst_din    (mst_din),
    .mst_wr_en  (mst_wr_en),
    .mst_afull  (mst_afull),
    .err_clr    (err_clr),
    .grant      (grant),
    .err_frm    (err_frm),
    .err_len    (err_len),
    .pkt_cnt0   (pkt_cnt0),
    .pkt_cnt1   (pkt_cnt1),
    .fsm_state  (fsm_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc++;

  // ---------------- output monitor ----------------
  logic [17:0] obs_q[$];
  int          obs_cyc_q[$];
  logic [1:0]  gnt_q[$];
  logic [1:0]  prev_grant = 2'b00;
  logic        afull_at_edge = 1'b0;
  int          afull_viol = 0;

  always @(posedge sys_clk) afull_at_edge = mst_afull;

  always @(negedge sys_clk) begin
    if (mst_wr_en === 1'b1) begin
      obs_q.push_back(mst_din);
      obs_cyc_q.push_back(cyc);
      if (afull_at_edge) afull_viol++;
    end
    if (grant !== 2'b00 && prev_grant === 2'b00) gnt_q.push_back(grant);
    prev_grant = grant;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int src, input logic [17:0] w, input logic v);
    if (src == 0) begin
      req0_din = w; req0_valid = v;
    end else begin
      req1_din = w; req1_valid = v;
    end
  endtask

  function automatic logic ready_of(input int src);
    return (src == 0) ? req0_ready : req1_ready;
  endfunction

  // Packet word i of n for requester src, packet number p.
  function automatic logic [17:0] pw(input int src, input int p, input int i, input int n);
    logic [15:0] d;
    d = {4'(src + 4'd3), 4'(p), 8'(i)};
    return {(i == 0), (i == n - 1), d};
  endfunction

  task automatic send_word(input int src, input logic [17:0] w);
    int t;
    t = 0;
    drive(src, w, 1'b1);
    forever begin
      @(negedge sys_clk);
      if (ready_of(src)) begin
        @(posedge sys_clk); #1;
        break;
      end
      @(posedge sys_clk); #1;
      t++;
      if (t > 300) begin
        n_vec++; n_err++;
        $display("FAIL send_word_timeout src=%0d word=%h got no ready within 300 cycles", src, w);
        break;
      end
    end
  endtask

  task automatic send_pkt(input int src, input int p, input int n);
    for (int i = 0; i < n; i++) send_word(src, pw(src, p, i, n));
    drive(src, 18'd0, 1'b0);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    drive(0, 18'd0, 1'b0);
    drive(1, 18'd0, 1'b0);
    mst_afull = 1'b0;
    err_clr   = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    obs_q.delete(); obs_cyc_q.delete(); gnt_q.delete();
    afull_viol = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    @(negedge sys_clk);
    n_vec++; if (grant !== 2'b00) begin n_err++; $display("FAIL reset_grant got=%b exp=00", grant); end
    n_vec++; if (mst_wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got=%b exp=0", mst_wr_en); end
    n_vec++; if (mst_din !== 18'd0) begin n_err++; $display("FAIL reset_din got=%h exp=0", mst_din); end
    n_vec++; if ({err_frm, err_len} !== 2'b00) begin n_err++; $display("FAIL reset_err got=%b%b exp=00", err_frm, err_len); end
    n_vec++; if ({pkt_cnt0, pkt_cnt1} !== 16'd0) begin n_err++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", pkt_cnt0, pkt_cnt1); end
    n_vec++; if (fsm_state !== 2'd0) begin n_err++; $display("FAIL reset_state got=%0d exp=0", fsm_state); end
    n_vec++; if ({req0_ready, req1_ready} !== 2'b00) begin n_err++; $display("FAIL reset_ready got=%b%b exp=00", req0_ready, req1_ready); end
    @(posedge sys_clk); #1;
  endtask

  task automatic test_single_packet();
    logic [17:0] exp_q[$];
    int c0, bad;
    do_reset();
    for (int i = 0; i < 35; i++)
      exp_q.push_back((i == 0) ? 18'h290FF : {1'b0, (i == 34), 16'(16'h1000 + i)});
    c0 = cyc;
    for (int i = 0; i < 35; i++) send_word(0, exp_q[i]);
    drive(0, 18'd0, 1'b0);
    repeat (4) @(posedge sys_clk);
    @(negedge sys_clk);
    n_vec++; if (obs_q.size() != 35) begin n_err++; $display("FAIL single_count got=%0d exp=35", obs_q.size()); end
    bad = 0;
    for (int i = 0; i < obs_q.size() && i < 35; i++) if (obs_q[i] !== exp_q[i]) bad++;
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL single_data mismatched_words=%0d exp=0", bad); end
    if (obs_cyc_q.size() == 35) begin
      n_vec++; if (obs_cyc_q[0] != c0 + 2) begin n_err++; $display("FAIL single_latency got_cycle=%0d exp=%0d", obs_cyc_q[0], c0 + 2); end
      n_vec++; if (obs_cyc_q[34] != c0 + 36) begin n_err++; $display("FAIL single_burst last_cycle=%0d exp=%0d", obs_cyc_q[34], c0 + 36); end
    end
    n_vec++; if (pkt_cnt0 !== 8'd1) begin n_err++; $display("FAIL single_pkt_cnt0 got=%0d exp=1", pkt_cnt0); end
    n_vec++; if (grant !== 2'b00) begin n_err++; $display("FAIL single_grant_idle got=%b exp=00", grant); end
    n_vec++; if (gnt_q.size() != 1 || gnt_q[0] !== 2'b01) begin n_err++; $display("FAIL single_grant_seq got_n=%0d exp=1 grant 01", gnt_q.size()); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_order[6];
    logic [17:0] exp_q[$];
    int pc[2];
    int bad, src, n;
    do_reset();
`ifdef ARB_FIXED_PRIO_EN
    exp_order = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10};
`else
    exp_order = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`endif
    fork
      begin for (int p = 0; p < 3; p++) send_pkt(0, p, 4); end
      begin for (int p = 0; p < 3; p++) send_pkt(1, p, 3); end
    join
    repeat (5) @(posedge sys_clk);
    @(negedge sys_clk);
    n_vec++; if (gnt_q.size() != 6) begin n_err++; $display("FAIL rr_grant_count got=%0d exp=6", gnt_q.size()); end
    for (int k = 0; k < 6 && k < gnt_q.size(); k++) begin
      n_vec++; if (gnt_q[k] !== exp_order[k]) begin n_err++; $display("FAIL rr_order[%0d] got=%b exp=%b", k, gnt_q[k], exp_order[k]); end
    end
    pc[0] = 0; pc[1] = 0;
    for (int k = 0; k < 6; k++) begin
      src = (exp_order[k] == 2'b01) ? 0 : 1;
      n = (src == 0) ? 4 : 3;
      for (int i = 0; i < n; i++) exp_q.push_back(pw(src, pc[src], i, n));
      pc[src]++;
    end
    n_vec++; if (obs_q.size() != 21) begin n_err++; $display("FAIL rr_word_count got=%0d exp=21", obs_q.size()); end
    bad = 0;
    for (int i = 0; i < obs_q.size() && i < 21; i++) if (obs_q[i] !== exp_q[i]) bad++;
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL rr_data mismatched_words=%0d exp=0", bad); end
    if (obs_cyc_q.size() == 21) begin
      n_vec++; if (obs_cyc_q[20] - obs_cyc_q[0] != 25) begin n_err++; $display("FAIL rr_bubbles span=%0d exp=25", obs_cyc_q[20] - obs_cyc_q[0]); end
    end
    n_vec++; if (pkt_cnt0 !== 8'd3 || pkt_cnt1 !== 8'd3) begin n_err++; $display("FAIL rr_pkt_cnt got=%0d/%0d exp=3/3", pkt_cnt0, pkt_cnt1); end
  endtask

  task automatic test_afull();
    int bad;
    do_reset();
    fork
      send_pkt(1, 0, 8);
      begin
        for (int k = 0; k < 40; k++) begin
          mst_afull = ((k / 3) % 2) == 1;
          @(posedge sys_clk); #1;
        end
        mst_afull = 1'b0;
      end
    join
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    n_vec++; if (afull_viol != 0) begin n_err++; $display("FAIL afull_write_while_full got=%0d exp=0", afull_viol); end
    n_vec++; if (obs_q.size() != 8) begin n_err++; $display("FAIL afull_count got=%0d exp=8", obs_q.size()); end
    bad = 0;
    for (int i = 0; i < obs_q.size() && i < 8; i++) if (obs_q[i] !== pw(1, 0, i, 8)) bad++;
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL afull_data mismatched_words=%0d exp=0", bad); end
    n_vec++; if (pkt_cnt1 !== 8'd1) begin n_err++; $display("FAIL afull_pkt_cnt1 got=%0d exp=1", pkt_cnt1); end
  endtask

  task automatic test_stray();
    do_reset();
    drive(1, 18'h00005, 1'b1);
    @(negedge sys_clk);
    n_vec++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL stray_ready got=%b exp=1", req1_ready); end
    @(posedge sys_clk); #1;
    drive(1, 18'd0, 1'b0);
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    n_vec++; if (err_frm !== 1'b1) begin n_err++; $display("FAIL stray_err_frm got=%b exp=1", err_frm); end
    n_vec++; if (err_len !== 1'b0) begin n_err++; $display("FAIL stray_err_len got=%b exp=0", err_len); end
    n_vec++; if (obs_q.size() != 0) begin n_err++; $display("FAIL stray_no_write got=%0d exp=0", obs_q.size()); end
    n_vec++; if (fsm_state !== 2'd0) begin n_err++; $display("FAIL stray_state got=%0d exp=0", fsm_state); end
    @(posedge sys_clk); #1;
    err_clr = 1'b1;
    @(posedge sys_clk); #1;
    err_clr = 1'b0;
    @(negedge sys_clk);
    n_vec++; if (err_frm !== 1'b0) begin n_err++; $display("FAIL stray_clear got=%b exp=0", err_frm); end
    // Set and clear in the same cycle: set must win.
    @(posedge sys_clk); #1;
    err_clr = 1'b1;
    drive(0, 18'h00007, 1'b1);
    @(posedge sys_clk); #1;
    err_clr = 1'b0;
    drive(0, 18'd0, 1'b0);
    @(negedge sys_clk);
    n_vec++; if (err_frm !== 1'b1) begin n_err++; $display("FAIL stray_set_wins got=%b exp=1", err_frm); end
  endtask

  task automatic test_max_len();
    int bad;
    logic [17:0] w, e;
    do_reset();
    for (int i = 0; i < 50; i++)
      send_word(0, {(i == 0), (i == 49), 16'(16'hA000 + i)});
    drive(0, 18'd0, 1'b0);
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    n_vec++; if (obs_q.size() != 40) begin n_err++; $display("FAIL len_count got=%0d exp=40", obs_q.size()); end
    bad = 0;
    for (int i = 0; i < obs_q.size() && i < 40; i++) begin
      w = obs_q[i];
      e = {(i == 0), (i == 39), 16'(16'hA000 + i)};
      if (w !== e) bad++;
    end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL len_data mismatched_words=%0d exp=0", bad); end
    n_vec++; if (err_len !== 1'b1) begin n_err++; $display("FAIL len_err_len got=%b exp=1", err_len); end
    n_vec++; if (err_frm !== 1'b1) begin n_err++; $display("FAIL len_err_frm got=%b exp=1", err_frm); end
    n_vec++; if (pkt_cnt0 !== 8'd1) begin n_err++; $display("FAIL len_pkt_cnt0 got=%0d exp=1", pkt_cnt0); end
    n_vec++; if (grant !== 2'b00) begin n_err++; $display("FAIL len_grant got=%b exp=00", grant); end
  endtask

  task automatic test_reset_mid_packet();
    int bad;
    do_reset();
    for (int i = 0; i < 10; i++) send_word(0, pw(0, 0, i, 20));
    sys_rst_n = 1'b0;
    drive(0, 18'd0, 1'b0);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    n_vec++; if (grant !== 2'b00) begin n_err++; $display("FAIL rstmid_grant got=%b exp=00", grant); end
    n_vec++; if (mst_wr_en !== 1'b0) begin n_err++; $display("FAIL rstmid_wr_en got=%b exp=0", mst_wr_en); end
    n_vec++; if ({pkt_cnt0, pkt_cnt1} !== 16'd0) begin n_err++; $display("FAIL rstmid_cnt got=%0d/%0d exp=0/0", pkt_cnt0, pkt_cnt1); end
    n_vec++; if (fsm_state !== 2'd0) begin n_err++; $display("FAIL rstmid_state got=%0d exp=0", fsm_state); end
    obs_q.delete(); obs_cyc_q.delete(); gnt_q.delete();
    @(posedge sys_clk); #1;
    send_pkt(1, 1, 5);
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    n_vec++; if (gnt_q.size() != 1 || gnt_q[0] !== 2'b10) begin n_err++; $display("FAIL rstmid_regrant got_n=%0d exp=1 grant 10", gnt_q.size()); end
    n_vec++; if (obs_q.size() != 5) begin n_err++; $display("FAIL rstmid_count got=%0d exp=5", obs_q.size()); end
    bad = 0;
    for (int i = 0; i < obs_q.size() && i < 5; i++) if (obs_q[i] !== pw(1, 1, i, 5)) bad++;
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL rstmid_data mismatched_words=%0d exp=0", bad); end
    n_vec++; if (pkt_cnt1 !== 8'd1 || pkt_cnt0 !== 8'd0) begin n_err++; $display("FAIL rstmid_pkt_cnt got=%0d/%0d exp=0/1", pkt_cnt0, pkt_cnt1); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_afull();
    test_stray();
    test_max_len();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
